uart_packet_tx: RTL and testbench

- Buffered RS-232 transmitter for the FFT result uplink. Accepts bytes with a packet-end marker through a valid/ready stream and stores them in an internal FIFO.
- Serialises each byte with configurable parity and stop bits.
- After each packet it inserts a guaranteed idle gap on the line. This lets the far-end receiver's idle/end-of-packet detection delimit packets.
- Sits between the spectrum formatter and the board TxD pin.

---
 rtl/uart_packet_tx.sv | 128 ++++++++++++
 tb/tb_uart_packet_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// Buffered UART transmitter: a byte FIFO feeds a start/data/parity/stop serialiser
// that holds the line idle for a fixed gap after every packet-ending byte.
module uart_packet_tx #(
  parameter int CLK_FREQ   = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int GAP_BITS   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_data,
  input  logic                        in_last,
  output logic                        TxD,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int DIV     = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int TW      = $clog2(DIV);
  localparam int MAXBITS = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int IW      = $clog2(MAXBITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} stateT;

  stateT         state, nextState;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [TW-1:0] timerCnt;
  logic [IW-1:0] bitIdx;
  logic [7:0]    shiftReg;
  logic [8:0]    headEntry;
  logic          lastReg, parityBit, txNext, bitEnd, doWrite, doPop;

  assign in_ready   = ~rst & (count != CW'(FIFO_DEPTH));
  assign doWrite    = in_valid & in_ready;
  assign headEntry  = mem[rdPtr];
  assign bitEnd     = (timerCnt == TW'(DIV - 1));
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= {in_last, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doPop)   rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // A character always passes through IDLE for one clock, which is where the pop happens
  always_comb begin
    nextState = state;
    doPop     = 1'b0;
    case (state)
      IDLE:  if (count != '0) begin
               doPop     = 1'b1;
               nextState = START;
             end
      START: if (bitEnd) nextState = DATA;
      DATA:  if (bitEnd && bitIdx == IW'(7)) nextState = (PARITY != 0) ? PAR : STOP;
      PAR:   if (bitEnd) nextState = STOP;
      STOP:  if (bitEnd && bitIdx == IW'(STOP_BITS - 1))
               nextState = (lastReg && GAP_BITS > 0) ? GAP : IDLE;
      GAP:   if (bitEnd && bitIdx == IW'(GAP_BITS - 1)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    txNext = 1'b1;
    case (state)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftReg[0];
      PAR:     txNext = parityBit;
      default: txNext = 1'b1;
    endcase
  end

  // TxD and busy are registered from the current state, so they trail the FSM by one clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timerCnt  <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      lastReg   <= 1'b0;
      parityBit <= 1'b0;
      TxD       <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state <= nextState;
      TxD   <= txNext;
      busy  <= (count != '0) || (state != IDLE);
      if (state == IDLE || nextState != state) begin
        timerCnt <= '0;
        bitIdx   <= '0;
      end else if (bitEnd) begin
        timerCnt <= '0;
        bitIdx   <= bitIdx + 1'b1;
      end else begin
        timerCnt <= timerCnt + 1'b1;
      end
      if (doPop) begin
        shiftReg  <= headEntry[7:0];
        lastReg   <= headEntry[8];
        parityBit <= (^headEntry[7:0]) ^ (PARITY == 2);
      end else if (state == DATA && bitEnd) begin
        shiftReg <= shiftReg >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: two configurations driven in parallel, each compared every
// clock against a line-level model, plus table vectors and hand-written corner sequences.
module tb_uart_packet_tx;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic [7:0] inData = 8'h00;
  logic       inLast = 1'b0;
  logic       txA, readyA, busyA, txB, readyB, busyB;
  logic [2:0] countA;
  logic [4:0] countB;

  int tests = 0;
  int failures = 0;
  int cyc = 0;

  uart_packet_tx #(.CLK_FREQ(800), .BAUD(100), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY(1), .GAP_BITS(4))
    dutA (.clk(clk), .rst(rst), .in_valid(inValid), .in_ready(readyA), .in_data(inData),
          .in_last(inLast), .TxD(txA), .busy(busyA), .fifo_count(countA));

  uart_packet_tx #(.CLK_FREQ(800), .BAUD(100), .FIFO_DEPTH(16), .STOP_BITS(2), .PARITY(2), .GAP_BITS(0))
    dutB (.clk(clk), .rst(rst), .in_valid(inValid), .in_ready(readyB), .in_data(inData),
          .in_last(inLast), .TxD(txB), .busy(busyB), .fifo_count(countB));

  initial forever #5 clk = ~clk;

  function automatic int depthOf(input int i);  return (i == 0) ? 4 : 16; endfunction
  function automatic int parityOf(input int i); return (i == 0) ? 1 : 2;  endfunction
  function automatic int stopOf(input int i);   return (i == 0) ? 1 : 2;  endfunction
  function automatic int gapOf(input int i);    return (i == 0) ? 4 : 0;  endfunction

  // Reference model: FIFO contents plus the per-clock line waveform of the character in flight
  logic [8:0] fifoM [2][16];
  int         head [2], fc [2], idleFrom [2], linePos [2], lineLen [2];
  logic       lineBits [2][256];
  logic       expTx [2], expBusy [2];

  task automatic loadFrame(input int i, input logic [8:0] item);
    int   ones, n, nSym;
    logic b;
    ones = $countones(item[7:0]);
    n = 0;
    nSym = 9 + ((parityOf(i) != 0) ? 1 : 0) + stopOf(i) + (item[8] ? gapOf(i) : 0);
    for (int s = 0; s < nSym; s++) begin
      if (s == 0) b = 1'b0;
      else if (s <= 8) b = item[s-1];
      else if (s == 9 && parityOf(i) != 0) b = (parityOf(i) == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      else b = 1'b1;
      for (int c = 0; c < DIV; c++) begin
        lineBits[i][n] = b;
        n++;
      end
    end
    lineLen[i] = n;
    linePos[i] = 0;
  endtask

  task automatic modelStep(input int i);
    int         sizePre;
    bit         idlePre, wr, pp;
    logic [8:0] item;
    sizePre = fc[i];
    idlePre = (idleFrom[i] <= cyc - 1);
    wr = inValid && (sizePre != depthOf(i));
    pp = idlePre && (sizePre != 0);
    expBusy[i] = (sizePre != 0) || !idlePre;
    if (linePos[i] < lineLen[i]) begin
      expTx[i] = lineBits[i][linePos[i]];
      linePos[i]++;
    end else begin
      expTx[i] = 1'b1;
    end
    if (pp) begin
      item = fifoM[i][head[i]];
      head[i] = (head[i] + 1) % depthOf(i);
      fc[i]--;
      loadFrame(i, item);
      idleFrom[i] = cyc + lineLen[i];
    end
    if (wr) begin
      fifoM[i][(head[i] + fc[i]) % depthOf(i)] = {inLast, inData};
      fc[i]++;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        head[i] = 0; fc[i] = 0; idleFrom[i] = cyc; linePos[i] = 0; lineLen[i] = 0;
        expTx[i] = 1'b1; expBusy[i] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) modelStep(i);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last);
    @(negedge clk);
    inValid = valid;
    inData  = data;
    inLast  = last;
  endtask

  // Per-clock comparison of both instances, plus a line decoder for instance A
  logic [8:0] rxQ [$];
  int         startQ [$];
  int         monCnt = -1;
  logic [8:0] monSh = '0;

  initial forever begin
    @(posedge clk);
    #2;
    checkOutput("txA",    txA,    expTx[0]);
    checkOutput("busyA",  busyA,  expBusy[0]);
    checkOutput("countA", countA, fc[0]);
    checkOutput("readyA", readyA, (!rst && fc[0] != 4));
    checkOutput("txB",    txB,    expTx[1]);
    checkOutput("busyB",  busyB,  expBusy[1]);
    checkOutput("countB", countB, fc[1]);
    checkOutput("readyB", readyB, (!rst && fc[1] != 16));
    if (rst) begin
      monCnt = -1;
    end else if (monCnt < 0) begin
      if (txA == 1'b0) begin
        monCnt = 0;
        startQ.push_back(cyc);
      end
    end else begin
      monCnt++;
      if (monCnt % DIV == 4 && monCnt / DIV >= 1 && monCnt / DIV <= 9) monSh[monCnt / DIV - 1] = txA;
      if (monCnt == 10 * DIV + 4) begin
        rxQ.push_back(monSh);
        monCnt = -1;
      end
    end
  end

  function automatic logic [31:0] rxAt(input int i);
    return (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #3;
      k++;
    end while ((busyA || busyB) && k < budget);
    checkOutput("idleTimeout", (busyA || busyB), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       parA;
    logic       parB;
    int         fallA;
    int         fallB;
  } vecT;

  vecT        vecs [6];
  int         lowAt, fallA, fallB, b, wEdge;
  logic [8:0] shB;
  bit         acc, sawFull;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1,  90, 98};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1,  90, 98};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 122, 98};
    vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b0,  90, 98};
    vecs[4] = '{8'h37, 1'b1, 1'b1, 1'b0, 122, 98};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1,  90, 98};

    repeat (3) @(negedge clk);
    checkOutput("resetTxA", txA, 1);
    checkOutput("resetBusyA", busyA, 0);
    checkOutput("resetCountA", countA, 0);
    checkOutput("resetReadyA", readyA, 0);
    rst = 1'b0;
    #1;
    checkOutput("releaseReadyA", readyA, 1);

    // Single characters: latency, decoded bits, parity and busy duration
    for (int v = 0; v < 6; v++) begin
      rxQ.delete();
      applyStimulus(1'b1, vecs[v].data, vecs[v].last);
      applyStimulus(1'b0, 8'h00, 1'b0);
      lowAt = -1; fallA = -1; fallB = -1; shB = '0;
      for (int k = 1; k <= 300 && (fallA < 0 || fallB < 0); k++) begin
        @(posedge clk);
        #3;
        if (lowAt < 0 && txA == 1'b0) lowAt = k;
        if (fallA < 0 && !busyA) fallA = k;
        if (fallB < 0 && !busyB) fallB = k;
        if (k >= 2 && (k - 2) % DIV == 4 && (k - 2) / DIV >= 1 && (k - 2) / DIV <= 9)
          shB[(k - 2) / DIV - 1] = txB;
      end
      checkOutput("vecLatencyA", lowAt, 2);
      checkOutput("vecRxCountA", rxQ.size(), 1);
      checkOutput("vecFrameA", rxAt(0), {vecs[v].parA, vecs[v].data});
      checkOutput("vecFrameB", shB, {vecs[v].parB, vecs[v].data});
      checkOutput("vecBusyFallA", fallA, vecs[v].fallA);
      checkOutput("vecBusyFallB", fallB, vecs[v].fallB);
    end

    // Start-bit spacing with and without the packet gap
    startQ.delete();
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitIdle(1000);
    checkOutput("gapStarts", startQ.size(), 2);
    checkOutput("gapSpacing", (startQ.size() == 2) ? startQ[1] - startQ[0] : -1, 88 + 32 + 1);
    startQ.delete();
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitIdle(1000);
    checkOutput("noGapSpacing", (startQ.size() == 2) ? startQ[1] - startQ[0] : -1, 89);

    // Continuous burst of 0..9 into the 4-deep FIFO
    rxQ.delete();
    b = 0;
    sawFull = 0;
    for (int g = 0; g < 3000 && b < 10; g++) begin
      applyStimulus(1'b1, 8'(b), 1'b0);
      acc = (fc[0] != 4);
      @(posedge clk);
      #3;
      if (countA == 3'd4) sawFull = 1;
      if (acc) b++;
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitIdle(4000);
    checkOutput("burstFull", sawFull, 1);
    checkOutput("burstRxCount", rxQ.size(), 10);
    for (int i = 0; i < 10; i++) checkOutput("burstOrder", rxAt(i) & 32'hFF, i);

    // Write in the same cycle as the pop of the only stored byte
    rxQ.delete();
    applyStimulus(1'b1, 8'h6C, 1'b0);
    applyStimulus(1'b1, 8'h93, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("popWriteCountA", countA, 1);
    checkOutput("popWriteCountB", countB, 1);
    waitIdle(1000);
    checkOutput("popWriteRx0", rxAt(0), {1'b0, 8'h6C});
    checkOutput("popWriteRx1", rxAt(1), {1'b0, 8'h93});

    // Asynchronous reset in the middle of data bit 3
    applyStimulus(1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (36) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("preResetTxA", txA, 0);
    checkOutput("preResetCountA", countA, 1);
    rst = 1'b1;
    #1;
    checkOutput("asyncTxA", txA, 1);
    checkOutput("asyncCountA", countA, 0);
    checkOutput("asyncBusyA", busyA, 0);
    checkOutput("asyncReadyA", readyA, 0);
    checkOutput("asyncTxB", txB, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxQ.delete();
    startQ.delete();
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    wEdge = cyc;
    waitIdle(1000);
    checkOutput("postResetLatency", (startQ.size() == 1) ? startQ[0] - wEdge : -1, 2);
    checkOutput("postResetRx", rxAt(0), {1'b0, 8'h5A});
    checkOutput("postResetRxCount", rxQ.size(), 1);

    // Random traffic against the model
    for (int r = 0; r < 1500; r++)
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 4) == 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitIdle(4000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
